// File: rtl/dadda_mac_acc.sv
// Pipelined multiply-accumulate: registered operands feed a 16x16 carry-save
// multiplier, and the products of each in_last-delimited frame are summed and emitted as one result.

module dadda_16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);
  logic [31:0] s, c, pp, ns, nc;

  // Fold the partial products into a sum/carry pair, then do a single carry-propagate add.
  always_comb begin
    s = '0;
    c = '0;
    pp = '0;
    ns = '0;
    nc = '0;
    for (int i = 0; i < 16; i++) begin
      pp = b_i[i] ? (32'(a_i) << i) : 32'd0;
      ns = s ^ c ^ pp;
      nc = ((s & c) | (s & pp) | (c & pp)) << 1;
      s  = ns;
      c  = nc;
    end
    p_o = s + c;
  end
endmodule

module dadda_mac_acc #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [LEN_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic {EMPTY, ACCUM} acc_st_e;

  logic [2:1]       vld_pipe_q;
  logic [15:0]      s1_a_q, s1_b_q;
  logic             s1_last_q, s2_last_q;
  logic [31:0]      prod, s2_prod_q;
  acc_st_e          state_q;
  logic [ACC_W-1:0] acc_q, prod_ext, sum_d, out_acc_q;
  logic [LEN_W-1:0] cnt_q, cnt_d, out_cnt_q;
  logic             ovf_q, ovf_d, out_ovf_q, out_valid_q, carry, stall;
  logic [ACC_W-1:0] add_sum;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_cnt_q;
  assign out_ovf   = out_ovf_q;

  dadda_16 u_mul (.a_i(s1_a_q), .b_i(s1_b_q), .p_o(prod));

  assign prod_ext         = ACC_W'(s2_prod_q);
  assign {carry, add_sum} = {1'b0, acc_q} + {1'b0, prod_ext};

  always_comb begin
    sum_d = add_sum;
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    ovf_d = ovf_q | carry;
    if (state_q == EMPTY) begin
      sum_d = prod_ext;
      cnt_d = LEN_W'(1);
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_last_q   <= 1'b0;
      s2_prod_q   <= '0;
      s2_last_q   <= 1'b0;
      state_q     <= EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (!stall) begin
        vld_pipe_q <= {vld_pipe_q[1], in_valid};
        if (in_valid) begin
          s1_a_q    <= in_a;
          s1_b_q    <= in_b;
          s1_last_q <= in_last;
        end
        s2_prod_q <= prod;
        s2_last_q <= s1_last_q;
        if (vld_pipe_q[2]) begin
          if (s2_last_q) begin
            out_valid_q <= 1'b1;
            out_acc_q   <= sum_d;
            out_cnt_q   <= cnt_d;
            out_ovf_q   <= ovf_d;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            state_q     <= EMPTY;
          end else begin
            acc_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            state_q <= ACCUM;
          end
        end
      end
    end
  end
endmodule
